// File: rtl/regfile_dump_tx_if.sv
// Byte stream from the register-file dump reader to the UART transmitter.
// A byte moves on a rising edge where tx_valid && tx_ready; once raised, tx_valid and tx_data hold until that edge.
interface regfile_dump_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/regfile_dump_tx.sv
// Walks register indices FIRST_REG..LAST_REG through the debug read port and
// streams each 32-bit value MSB-first as bytes, optionally preceded by an index header.
module regfile_dump_tx #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31,
    parameter bit HEADER_EN = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start_i,
    output logic [4:0]                rf_addr_o,
    input  logic [31:0]               rf_data_i,
    regfile_dump_tx_if.master         tx,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [1:0]                state_o
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_DONE} state_e;

    localparam logic [4:0] FIRST_A = 5'(FIRST_REG);
    localparam logic [4:0] LAST_A  = 5'(LAST_REG);
    localparam logic [2:0] NBYTES  = HEADER_EN ? 3'd5 : 3'd4;

    state_e      state_q;
    logic [4:0]  addr_q;
    logic [31:0] snap_q;
    logic [2:0]  cnt_q;
    logic [7:0]  tx_data_q;
    logic        tx_valid_q;
    logic        busy_q;
    logic        done_q;

    logic [2:0]  cnt_d;
    logic [7:0]  byte_d;
    logic [7:0]  first_byte_d;

    // cnt_q counts bytes still to go for this register, including the one on the bus.
    always_comb begin
        cnt_d  = cnt_q - 3'd1;
        byte_d = 8'h00;
        case (cnt_d)
            3'd4:    byte_d = snap_q[31:24];
            3'd3:    byte_d = snap_q[23:16];
            3'd2:    byte_d = snap_q[15:8];
            3'd1:    byte_d = snap_q[7:0];
            default: byte_d = 8'h00;
        endcase
        first_byte_d = HEADER_EN ? {3'b000, addr_q} : rf_data_i[31:24];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= FIRST_A;
            snap_q     <= 32'h0;
            cnt_q      <= 3'd0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    addr_q <= FIRST_A;
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    snap_q     <= rf_data_i;
                    cnt_q      <= NBYTES;
                    tx_data_q  <= first_byte_d;
                    tx_valid_q <= 1'b1;
                    state_q    <= S_SEND;
                end
                S_SEND: begin
                    if (tx.tx_ready) begin
                        cnt_q <= cnt_d;
                        if (cnt_q == 3'd1) begin
                            tx_valid_q <= 1'b0;
                            if (addr_q == LAST_A) begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                addr_q  <= addr_q + 5'd1;
                                state_q <= S_LOAD;
                            end
                        end else begin
                            tx_data_q <= byte_d;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    addr_q  <= FIRST_A;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        assert (FIRST_REG >= 0 && FIRST_REG <= LAST_REG && LAST_REG <= 31)
            else $error("regfile_dump_tx: illegal FIRST_REG/LAST_REG configuration");
    end

    assign rf_addr_o   = addr_q;
    assign tx.tx_data  = tx_data_q;
    assign tx.tx_valid = tx_valid_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_regfile_dump_tx.sv
// Directed bench for regfile_dump_tx: three configurations share clock and reset,
// each with its own register-file model and expected-byte queue.
module tb_regfile_dump_tx;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt_full = 0;

  logic start_full = 1'b1;
  logic start_one  = 1'b1;
  logic start_hdr  = 1'b1;

  logic [31:0] rf_full [32];
  logic [31:0] rf_one  [32];
  logic [31:0] rf_hdr  [32];

  logic [4:0]  addr_full, addr_one, addr_hdr;
  logic [31:0] rd_full, rd_one, rd_hdr;
  logic        busy_full, busy_one, busy_hdr;
  logic        done_full, done_one, done_hdr;
  logic [1:0]  st_full, st_one, st_hdr;

  logic [7:0] exp_q_full[$];
  logic [7:0] exp_q_one[$];
  logic [7:0] exp_q_hdr[$];

  regfile_dump_tx_if if_full();
  regfile_dump_tx_if if_one();
  regfile_dump_tx_if if_hdr();

  assign rd_full = rf_full[addr_full];
  assign rd_one  = rf_one[addr_one];
  assign rd_hdr  = rf_hdr[addr_hdr];

  regfile_dump_tx #(.FIRST_REG(0), .LAST_REG(31), .HEADER_EN(1'b0)) u_full (
    .clk(clk), .reset(reset), .start_i(start_full), .rf_addr_o(addr_full),
    .rf_data_i(rd_full), .tx(if_full), .busy_o(busy_full), .done_o(done_full), .state_o(st_full)
  );

  regfile_dump_tx #(.FIRST_REG(5), .LAST_REG(5), .HEADER_EN(1'b0)) u_one (
    .clk(clk), .reset(reset), .start_i(start_one), .rf_addr_o(addr_one),
    .rf_data_i(rd_one), .tx(if_one), .busy_o(busy_one), .done_o(done_one), .state_o(st_one)
  );

  regfile_dump_tx #(.FIRST_REG(16), .LAST_REG(17), .HEADER_EN(1'b1)) u_hdr (
    .clk(clk), .reset(reset), .start_i(start_hdr), .rf_addr_o(addr_hdr),
    .rf_data_i(rd_hdr), .tx(if_hdr), .busy_o(busy_hdr), .done_o(done_hdr), .state_o(st_hdr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_byte(input int which, input logic [7:0] b);
    case (which)
      0:       exp_q_full.push_back(b);
      1:       exp_q_one.push_back(b);
      default: exp_q_hdr.push_back(b);
    endcase
  endtask

  task automatic push_word(input int which, input logic [31:0] w);
    for (int b = 3; b >= 0; b--) push_byte(which, w[8*b +: 8]);
  endtask

  task automatic got_byte(input int which, input logic [7:0] d);
    int sz;
    logic [7:0] e;
    case (which)
      0:       sz = exp_q_full.size();
      1:       sz = exp_q_one.size();
      default: sz = exp_q_hdr.size();
    endcase
    if (sz == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL byte%0d_extra: got %h expected no byte", which, d);
    end else begin
      case (which)
        0:       e = exp_q_full.pop_front();
        1:       e = exp_q_one.pop_front();
        default: e = exp_q_hdr.pop_front();
      endcase
      check($sformatf("byte%0d", which), 32'(d), 32'(e));
    end
  endtask

  // Transfers are sampled mid-cycle; inputs only change 2 time units after a rising edge.
  always @(negedge clk) begin
    if (!reset && if_full.tx_valid && if_full.tx_ready) got_byte(0, if_full.tx_data);
    if (!reset && if_one.tx_valid && if_one.tx_ready)   got_byte(1, if_one.tx_data);
    if (!reset && if_hdr.tx_valid && if_hdr.tx_ready)   got_byte(2, if_hdr.tx_data);
    if (done_full) done_cnt_full++;
  end

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int which, input int cyc_now, input int exp_cyc, input string tag);
    int c;
    logic d;
    c = cyc_now;
    d = 1'b0;
    while (!d && c < exp_cyc + 50) begin
      next_cycle();
      c++;
      case (which)
        0:       d = done_full;
        1:       d = done_one;
        default: d = done_hdr;
      endcase
    end
    check(tag, 32'(c), 32'(exp_cyc));
  endtask

  initial begin
    logic [31:0] w;
    for (int i = 0; i < 32; i++) begin
      rf_full[i] = 32'h0;
      rf_one[i]  = 32'h0;
      rf_hdr[i]  = 32'h0;
    end
    rf_full[29] = 32'h0000_0400;
    rf_one[5]   = 32'hDEAD_BEEF;
    rf_hdr[16]  = 32'h0000_00A5;
    rf_hdr[17]  = 32'h0000_0099;
    if_full.tx_ready = 1'b1;
    if_one.tx_ready  = 1'b1;
    if_hdr.tx_ready  = 1'b1;

    // Reset held two edges with start high.
    repeat (2) next_cycle();
    check("rst_valid", 32'(if_full.tx_valid), 32'd0);
    check("rst_data", 32'(if_full.tx_data), 32'h0);
    check("rst_busy", 32'(busy_full), 32'd0);
    check("rst_done", 32'(done_full), 32'd0);
    check("rst_addr", 32'(addr_full), 32'd0);
    check("rst_addr_one", 32'(addr_one), 32'd5);
    check("rst_state", 32'(st_full), 32'd0);
    reset = 1'b0;
    start_full = 1'b0;
    start_one  = 1'b0;
    start_hdr  = 1'b0;
    repeat (3) begin
      next_cycle();
      check("post_rst_busy", 32'(busy_full | busy_one | busy_hdr), 32'd0);
      check("post_rst_valid", 32'(if_full.tx_valid | if_one.tx_valid | if_hdr.tx_valid), 32'd0);
    end

    // Single register 5 = DEADBEEF, cycle-exact.
    w = 32'hDEAD_BEEF;
    push_word(1, w);
    start_one = 1'b1;
    next_cycle();
    start_one = 1'b0;
    check("one_c1_busy", 32'(busy_one), 32'd1);
    check("one_c1_valid", 32'(if_one.tx_valid), 32'd0);
    for (int c = 2; c <= 5; c++) begin
      next_cycle();
      check("one_busy", 32'(busy_one), 32'd1);
      check("one_valid", 32'(if_one.tx_valid), 32'd1);
      check("one_data", 32'(if_one.tx_data), 32'(w[8*(5-c) +: 8]));
    end
    next_cycle();
    check("one_c6_done", 32'(done_one), 32'd1);
    check("one_c6_busy", 32'(busy_one), 32'd0);
    check("one_c6_valid", 32'(if_one.tx_valid), 32'd0);
    start_one = 1'b1;
    next_cycle();
    start_one = 1'b0;
    check("one_c7_done", 32'(done_one), 32'd0);
    check("one_c7_busy", 32'(busy_one), 32'd0);
    next_cycle();
    check("one_start_in_done_ignored", 32'(busy_one), 32'd0);
    check("one_q_empty", 32'(exp_q_one.size()), 32'd0);

    // Backpressure: ready low three cycles while 0x22 is on the bus.
    rf_one[5] = 32'h1122_3344;
    push_word(1, 32'h1122_3344);
    start_one = 1'b1;
    next_cycle();
    start_one = 1'b0;
    next_cycle();
    check("bp_c2_data", 32'(if_one.tx_data), 32'h11);
    next_cycle();
    check("bp_c3_data", 32'(if_one.tx_data), 32'h22);
    if_one.tx_ready = 1'b0;
    repeat (3) begin
      next_cycle();
      check("bp_hold_data", 32'(if_one.tx_data), 32'h22);
      check("bp_hold_valid", 32'(if_one.tx_valid), 32'd1);
    end
    if_one.tx_ready = 1'b1;
    wait_done(1, 6, 9, "bp_done_cycle");
    check("bp_q_empty", 32'(exp_q_one.size()), 32'd0);

    // Header mode with snapshot: reg16 changes mid-send, reg17 changes before its load.
    push_byte(2, 8'h10);
    push_word(2, 32'h0000_00A5);
    push_byte(2, 8'h11);
    push_word(2, 32'h0000_003C);
    start_hdr = 1'b1;
    next_cycle();
    start_hdr = 1'b0;
    next_cycle();
    check("hdr_first_byte", 32'(if_hdr.tx_data), 32'h10);
    next_cycle();
    rf_hdr[16] = 32'hFFFF_FFFF;
    rf_hdr[17] = 32'h0000_003C;
    start_hdr  = 1'b1;
    next_cycle();
    start_hdr = 1'b0;
    wait_done(2, 4, 13, "hdr_done_cycle");
    check("hdr_q_empty", 32'(exp_q_hdr.size()), 32'd0);

    // Full dump of post-reset state, with a stray start mid-dump.
    for (int r = 0; r < 32; r++) push_word(0, rf_full[r]);
    start_full = 1'b1;
    next_cycle();
    start_full = 1'b0;
    check("full_c1_addr", 32'(addr_full), 32'd0);
    check("full_c1_busy", 32'(busy_full), 32'd1);
    for (int c = 2; c <= 60; c++) begin
      next_cycle();
      start_full = (c == 50);
    end
    start_full = 1'b0;
    wait_done(0, 60, 161, "full_done_cycle");
    check("full_q_empty", 32'(exp_q_full.size()), 32'd0);
    next_cycle();
    check("full_done_count", 32'(done_cnt_full), 32'd1);

    // Abort with reset after the second byte of register 3.
    rf_full[3] = 32'h0102_0304;
    for (int r = 0; r < 3; r++) push_word(0, rf_full[r]);
    push_byte(0, 8'h01);
    push_byte(0, 8'h02);
    start_full = 1'b1;
    next_cycle();
    start_full = 1'b0;
    for (int c = 2; c <= 18; c++) next_cycle();
    check("abort_c18_data", 32'(if_full.tx_data), 32'h02);
    next_cycle();
    check("abort_c19_data", 32'(if_full.tx_data), 32'h03);
    reset = 1'b1;
    if_full.tx_ready = 1'b0;
    next_cycle();
    check("abort_valid", 32'(if_full.tx_valid), 32'd0);
    check("abort_busy", 32'(busy_full), 32'd0);
    check("abort_done", 32'(done_full), 32'd0);
    check("abort_addr", 32'(addr_full), 32'd0);
    reset = 1'b0;
    if_full.tx_ready = 1'b1;
    repeat (5) next_cycle();
    check("abort_no_done", 32'(done_cnt_full), 32'd1);
    check("abort_idle", 32'(busy_full), 32'd0);
    check("abort_q_empty", 32'(exp_q_full.size()), 32'd0);

    // Fresh start restarts at FIRST_REG and runs to completion.
    for (int r = 0; r < 32; r++) push_word(0, rf_full[r]);
    start_full = 1'b1;
    next_cycle();
    start_full = 1'b0;
    check("restart_addr", 32'(addr_full), 32'd0);
    check("restart_busy", 32'(busy_full), 32'd1);
    next_cycle();
    check("restart_first_byte", 32'(if_full.tx_data), 32'h00);
    check("restart_valid", 32'(if_full.tx_valid), 32'd1);
    wait_done(0, 2, 161, "restart_done_cycle");
    next_cycle();
    check("restart_q_empty", 32'(exp_q_full.size()), 32'd0);
    check("restart_done_count", 32'(done_cnt_full), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_dump_tx.md
Name: regfile_dump_tx

Overview:
- Debug reader for the CPU register file; the counterpart to the pipeline's writeback port.
- On a start pulse it walks register indices FIRST_REG..LAST_REG through a dedicated combinational read port.
- Each 32-bit value is snapshotted and streamed out MSB-first as bytes on a valid/ready byte interface, which feeds the board UART transmitter.
- Lets the bench and the board inspect architectural state, including $sp = 0x00000400 after reset, without halting the pipeline.

Parameters:
- FIRST_REG, 0: first register index dumped (0..31).
- LAST_REG, 31: last register index dumped (FIRST_REG..31).
- HEADER_EN, 0: when 1, send one header byte {3'b000, index} before each register's four data bytes.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a dump; ignored unless in IDLE.
- rf_addr  output  5  read address driven to the register file debug read port.
- rf_data  input  32  combinational read data for rf_addr, valid in the same cycle; index 0 reads 0.
- tx_data  output  8  current byte.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  downstream accepts the byte this cycle.
- busy  output  1  dump in progress (LOAD or SEND).
- done  output  1  one-cycle pulse after the final byte is accepted.

Behaviour:
- Reset values: state IDLE, rf_addr = FIRST_REG, tx_data = 0, tx_valid = 0, busy = 0, done = 0, byte counter = 0, snapshot = 0.
- Reset takes priority over all other inputs in every state. A reset mid-dump aborts immediately: no done pulse; tx_valid is low the cycle after the reset edge.
- State IDLE:
  - rf_addr = FIRST_REG.
  - start = 1 at an edge -> LOAD.
- State LOAD (exactly one cycle):
  - Capture rf_data into a 32-bit snapshot.
  - Load the byte counter with 4, or 5 if HEADER_EN.
  - -> SEND.
  - Register writes after this edge do not affect the bytes sent for this index; writes to higher indices before their own LOAD are reflected.
- State SEND:
  - tx_valid = 1.
  - tx_data is the header byte (if HEADER_EN and it has not yet been sent), otherwise snapshot[31:24], then [23:16], then [15:8], then [7:0].
  - A byte transfers on an edge with tx_valid && tx_ready; the byte counter then decrements and the next byte is presented.
  - While tx_ready = 0, tx_data and tx_valid hold unchanged. tx_valid is never dropped mid-register.
  - On acceptance of the last byte:
    - if rf_addr == LAST_REG -> DONE;
    - else rf_addr increments by 1 -> LOAD.
  - tx_valid is low in the LOAD cycle between registers.
- State DONE (one cycle):
  - done = 1, busy = 0, tx_valid = 0.
  - -> IDLE. A start in this cycle is ignored.
- busy = 1 exactly in LOAD and SEND. A start seen while busy or in DONE has no effect and is not queued.
- Latency:
  - start at edge E0 -> LOAD during cycle 1 -> first byte valid in cycle 2.
  - With tx_ready held high, each register costs 1 + 4 cycles (1 + 5 with HEADER_EN).
  - A full 32-register dump presents 128 bytes (160 with header), and done asserts in cycle 32*5 + 1 = 161 after E0 (193 with header).
- rf_addr never exceeds LAST_REG and never wraps. FIRST_REG == LAST_REG dumps a single register.
- Index 0 is dumped as 0x00000000 (the register file guarantees it); the block does not special-case it.
- Parameter violations (FIRST_REG > LAST_REG or > 31) are illegal configurations; simulation-only assertion.

Test Plan:
- Reset check: assert reset 2 cycles, with start high during reset -> tx_valid = 0, busy = 0, done = 0, rf_addr = 0; no dump begins after reset is released.
- Single register, FIRST_REG = LAST_REG = 5, rf_data[5] = 0xDEADBEEF, tx_ready = 1:
  - start -> bytes DE, AD, BE, EF on 4 consecutive cycles starting cycle 2;
  - done high in cycle 6;
  - busy high in cycles 1-5.
- Full dump after CPU reset, tx_ready = 1:
  - 128 bytes; bytes 0-3 = 00 00 00 00 (reg 0);
  - bytes 116-119 = 00 00 04 00 (reg 29); all others 0;
  - done in cycle 161.
- Backpressure, FIRST_REG = LAST_REG = 5, rf_data = 0x11223344: tx_ready low 3 cycles during byte 0x22 -> tx_data holds 0x22 with tx_valid high; sequence 11, 22, 33, 44 intact; done delayed by 3 cycles.
- Header and snapshot, HEADER_EN = 1, FIRST_REG = 16, LAST_REG = 17, reg16 = 0xA5, reg17 = 0x3C:
  - expected sequence 10 00 00 00 A5 11 00 00 00 3C;
  - changing rf_data for reg16 during its SEND does not alter its bytes.
- Abort and ignore:
  - start pulsed again mid-dump -> no effect on the sequence;
  - reset after byte 2 of register 3 -> IDLE next cycle, no done;
  - a fresh start then restarts at FIRST_REG.
